// File: rtl/cell_test_sequencer.sv
// rtl/cell_test_sequencer.sv - standard-cell stimulus walker and response checker with Wishbone registers
module cell_test_sequencer #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 2
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             wbs_stb_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_dat_i,
    input  logic [31:0]      wbs_adr_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    output logic [IN_W-1:0]  stim_o,
    input  logic [OUT_W-1:0] resp_i,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SETTLE = 2'd2,
        SAMPLE = 2'd3
    } state_t;

    localparam logic [2:0] IN_W3    = 3'(IN_W);
    localparam logic [1:0] OUT_MASK = (OUT_W >= 2) ? 2'b11 : 2'b01;

    state_t      state, state_nxt;
    logic        ack_q;
    logic [31:0] dat_q;
    logic [2:0]  nin_r;
    logic [1:0]  cmp_en_r;
    logic [7:0]  settle_r;
    logic [31:0] expect_r;
    logic [3:0]  vec;
    logic [7:0]  cnt;
    logic [3:0]  stim_r;
    logic [15:0] cap0, cap1;
    logic [7:0]  mm_count;
    logic [4:0]  first_fail;
    logic        done_r;

    logic        req, bus_wr, wr_ctrl, wr_exp;
    logic        start_req, abort_req, idle;
    logic [2:0]  nin_eff;
    logic [4:0]  last_vec;
    logic [7:0]  settle_eff;
    logic [1:0]  resp_ext, exp_bits;
    logic        mismatch, is_last, pass;
    logic [31:0] rd_data;
    logic        unused_bits;

    assign unused_bits = ^{wbs_adr_i[31:4], wbs_adr_i[1:0]};

    // A request is accepted when no ack is outstanding; register writes commit in the ack cycle
    assign req       = wbs_stb_i & wbs_cyc_i;
    assign bus_wr    = ack_q & req & wbs_we_i;
    assign wr_ctrl   = bus_wr & (wbs_adr_i[3:2] == 2'd0);
    assign wr_exp    = bus_wr & (wbs_adr_i[3:2] == 2'd1);
    assign abort_req = wr_ctrl & wbs_sel_i[0] & wbs_dat_i[1];
    assign start_req = wr_ctrl & wbs_sel_i[0] & wbs_dat_i[0] & ~wbs_dat_i[1];
    assign idle      = (state == IDLE);

    // Effective input count, last vector index and settle time
    always_comb begin
        if (nin_r == 3'd0)
            nin_eff = 3'd1;
        else if (nin_r > IN_W3)
            nin_eff = IN_W3;
        else
            nin_eff = nin_r;
        last_vec   = (5'd1 << nin_eff) - 5'd1;
        settle_eff = (settle_r == 8'd0) ? 8'd1 : settle_r;
    end

    // Response comparison for the vector currently being sampled
    always_comb begin
        resp_ext = '0;
        resp_ext[OUT_W-1:0] = resp_i;
        exp_bits = {expect_r[5'd16 + {1'b0, vec}], expect_r[vec]};
        mismatch = |((resp_ext ^ exp_bits) & cmp_en_r & OUT_MASK);
        is_last  = ({1'b0, vec} == last_vec);
    end

    assign pass   = done_r & (mm_count == 8'd0);
    assign busy_o = ~idle;
    assign done_o = done_r;
    assign stim_o = stim_r[IN_W-1:0];

    // Register read multiplexer
    always_comb begin
        rd_data = '0;
        case (wbs_adr_i[3:2])
            2'd0:    rd_data = {8'd0, settle_r, 2'd0, cmp_en_r, 1'b0, nin_r, 8'd0};
            2'd1:    rd_data = expect_r;
            2'd2:    rd_data = {11'd0, first_fail, mm_count, 5'd0, pass, done_r, busy_o};
            default: rd_data = {cap1, cap0};
        endcase
    end

    // Wishbone handshake: single-cycle ack, never two in a row, data only in the ack cycle
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= req & ~ack_q;
            dat_q <= (req & ~ack_q & ~wbs_we_i) ? rd_data : 32'd0;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;

    // Configuration registers; frozen while a sequence runs
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            nin_r    <= '0;
            cmp_en_r <= '0;
            settle_r <= '0;
            expect_r <= '0;
        end else if (idle) begin
            if (wr_ctrl && wbs_sel_i[1]) begin
                nin_r    <= wbs_dat_i[10:8];
                cmp_en_r <= wbs_dat_i[13:12];
            end
            if (wr_ctrl && wbs_sel_i[2])
                settle_r <= wbs_dat_i[23:16];
            if (wr_exp) begin
                for (int b = 0; b < 4; b++)
                    if (wbs_sel_i[b])
                        expect_r[b*8 +: 8] <= wbs_dat_i[b*8 +: 8];
            end
        end
    end

    // Sequencer state register
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; abort overrides everything
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_req) state_nxt = APPLY;
            APPLY:   state_nxt = SETTLE;
            SETTLE:  if (cnt == 8'd1) state_nxt = SAMPLE;
            SAMPLE:  state_nxt = is_last ? IDLE : APPLY;
            default: state_nxt = IDLE;
        endcase
        if (abort_req)
            state_nxt = IDLE;
    end

    // Sequencer datapath: vector index, settle counter, stimulus, capture and result tracking
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            vec        <= '0;
            cnt        <= '0;
            stim_r     <= '0;
            cap0       <= '0;
            cap1       <= '0;
            mm_count   <= '0;
            first_fail <= 5'h1F;
            done_r     <= 1'b0;
        end else if (abort_req) begin
            stim_r <= '0;
            done_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    stim_r <= '0;
                    if (start_req) begin
                        cap0       <= '0;
                        cap1       <= '0;
                        mm_count   <= '0;
                        first_fail <= 5'h1F;
                        done_r     <= 1'b0;
                        vec        <= '0;
                    end
                end
                APPLY: begin
                    stim_r <= vec;
                    cnt    <= settle_eff;
                end
                SETTLE: begin
                    cnt <= cnt - 8'd1;
                end
                SAMPLE: begin
                    cap0[vec] <= resp_ext[0];
                    cap1[vec] <= resp_ext[1];
                    if (mismatch) begin
                        if (mm_count != 8'hFF)
                            mm_count <= mm_count + 8'd1;
                        if (first_fail == 5'h1F)
                            first_fail <= {1'b0, vec};
                    end
                    if (is_last) begin
                        done_r <= 1'b1;
                        stim_r <= '0;
                    end else begin
                        vec <= vec + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cell_test_sequencer.sv
// tb/tb_cell_test_sequencer.sv - scoreboard bench for cell_test_sequencer
module tb_cell_test_sequencer;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_ni = 1'b0;
    logic        wbs_stb_i = 1'b0;
    logic        wbs_cyc_i = 1'b0;
    logic        wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = '0;
    logic [31:0] wbs_dat_i = '0;
    logic [31:0] wbs_adr_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [3:0]  stim_o;
    logic [1:0]  resp_i;
    logic        busy_o;
    logic        done_o;

    int checks = 0;
    int errors = 0;
    logic model_sel = 1'b0;
    logic prev_ack = 1'b0;

    logic [31:0] exp_q[$];
    string       name_q[$];

    cell_test_sequencer #(.IN_W(4), .OUT_W(2)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_ni(wb_rst_ni),
        .wbs_stb_i(wbs_stb_i),
        .wbs_cyc_i(wbs_cyc_i),
        .wbs_we_i (wbs_we_i),
        .wbs_sel_i(wbs_sel_i),
        .wbs_dat_i(wbs_dat_i),
        .wbs_adr_i(wbs_adr_i),
        .wbs_ack_o(wbs_ack_o),
        .wbs_dat_o(wbs_dat_o),
        .stim_o   (stim_o),
        .resp_i   (resp_i),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Cell model: AND2 on output 0, output 1 either tied low or a buffer of input 0
    always_comb begin
        resp_i[0] = stim_o[0] & stim_o[1];
        resp_i[1] = model_sel ? stim_o[0] : 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops expected read data on each read ack, checks the post-ack gap
    always @(negedge wb_clk_i) begin
        if (prev_ack) begin
            chk("ack_gap", {31'd0, wbs_ack_o}, 32'd0);
            chk("dat_idle", wbs_dat_o, 32'd0);
        end
        if (wbs_ack_o && !wbs_we_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: got 0x%08h with no expectation", wbs_dat_o);
            end else begin
                chk(name_q.pop_front(), wbs_dat_o, exp_q.pop_front());
            end
        end
        prev_ack = wbs_ack_o;
    end

    task automatic bus(input logic we, input logic [1:0] a, input logic [3:0] sel, input logic [31:0] d);
        int n;
        @(negedge wb_clk_i);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = {28'd0, a, 2'b00};
        wbs_sel_i = sel;
        wbs_dat_i = d;
        n = 0;
        do begin
            @(negedge wb_clk_i);
            n++;
        end while (!wbs_ack_o && n < 8);
        if (!wbs_ack_o) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got no ack expected ack within 8 cycles");
        end
        @(negedge wb_clk_i);
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] sel, input logic [31:0] d);
        bus(1'b1, a, sel, d);
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
        exp_q.push_back(exp);
        name_q.push_back(name);
        bus(1'b0, a, 4'hF, 32'd0);
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 1;
        while (busy_o && cyc < 1000) begin
            @(negedge wb_clk_i);
            if (busy_o) cyc++;
        end
        if (busy_o) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy expected idle within 1000 cycles");
        end
    endtask

    initial begin
        int cyc;
        logic [3:0] stim_seq;
        logic [6:0] busy_seq;

        repeat (3) @(negedge wb_clk_i);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_stim", {28'd0, stim_o}, 32'd0);
        chk("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
        wb_rst_ni = 1'b1;
        rd(2'd2, 32'h001F0000, "rst_status");
        rd(2'd0, 32'h00000000, "rst_ctrl");
        rd(2'd3, 32'h00000000, "rst_capture");

        // AND2 passing run: nin=2 settle=3 cmp_en=01
        wr(2'd1, 4'hF, 32'h00000008);
        wr(2'd0, 4'hF, 32'h00031201);
        chk("start_busy", {31'd0, busy_o}, 32'd1);
        chk("start_stim", {28'd0, stim_o}, 32'd0);
        wait_idle(cyc);
        chk("and2_run_cycles", cyc, 20);
        chk("and2_done", {31'd0, done_o}, 32'd1);
        rd(2'd3, 32'h00000008, "and2_capture");
        rd(2'd2, 32'h001F0006, "and2_status");
        rd(2'd0, 32'h00031200, "and2_ctrl");

        // AND2 with wrong expectation
        wr(2'd1, 4'hF, 32'h0000000E);
        wr(2'd0, 4'hF, 32'h00031201);
        wait_idle(cyc);
        rd(2'd2, 32'h00010202, "fail_status");
        rd(2'd3, 32'h00000008, "fail_capture");

        // settle=0, nin=1: vector period of 3 cycles
        wr(2'd0, 4'hF, 32'h00000101);
        stim_seq = 4'd0;
        busy_seq = 7'b0111111;
        for (int i = 0; i < 7; i++) begin
            stim_seq = (i == 4 || i == 5) ? 4'd1 : 4'd0;
            chk($sformatf("s0_stim_%0d", i), {28'd0, stim_o}, {28'd0, stim_seq});
            chk($sformatf("s0_busy_%0d", i), {31'd0, busy_o}, {31'd0, busy_seq[i]});
            @(negedge wb_clk_i);
        end
        chk("s0_done", {31'd0, done_o}, 32'd1);
        rd(2'd2, 32'h001F0006, "s0_status");

        // Abort during vector 2 of a nin=3 run
        model_sel = 1'b1;
        wr(2'd0, 4'hF, 32'h00031301);
        repeat (11) @(negedge wb_clk_i);
        chk("abort_pre_stim", {28'd0, stim_o}, 32'd2);
        wr(2'd0, 4'hF, 32'h00000002);
        chk("abort_busy", {31'd0, busy_o}, 32'd0);
        chk("abort_stim", {28'd0, stim_o}, 32'd0);
        chk("abort_done", {31'd0, done_o}, 32'd0);
        rd(2'd2, 32'h00010100, "abort_status");
        rd(2'd3, 32'h00020000, "abort_capture");

        // Rerun clears capture; EXPECT is locked while busy
        wr(2'd0, 4'hF, 32'h000A0101);
        rd(2'd3, 32'h00000000, "rerun_capture_clr");
        rd(2'd2, 32'h001F0001, "rerun_status_busy");
        wr(2'd1, 4'hF, 32'hFFFFFFFF);
        wait_idle(cyc);
        rd(2'd1, 32'h0000000E, "busy_expect_locked");
        rd(2'd3, 32'h00020000, "rerun_capture");
        rd(2'd2, 32'h001F0006, "rerun_status");

        // Start and abort together: abort wins
        wr(2'd0, 4'hF, 32'h00031203);
        chk("start_abort_busy", {31'd0, busy_o}, 32'd0);
        chk("start_abort_done", {31'd0, done_o}, 32'd0);

        // Byte enables and back-to-back reads
        wr(2'd1, 4'hF, 32'h00000000);
        wr(2'd1, 4'b0010, 32'hFFFFFFFF);
        exp_q.push_back(32'h0000FF00);
        name_q.push_back("b2b_read0");
        exp_q.push_back(32'h0000FF00);
        name_q.push_back("b2b_read1");
        @(negedge wb_clk_i);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = 1'b0;
        wbs_adr_i = 32'h00000004;
        wbs_sel_i = 4'hF;
        @(negedge wb_clk_i);
        chk("b2b_ack_1", {31'd0, wbs_ack_o}, 32'd1);
        @(negedge wb_clk_i);
        chk("b2b_ack_2", {31'd0, wbs_ack_o}, 32'd0);
        @(negedge wb_clk_i);
        chk("b2b_ack_3", {31'd0, wbs_ack_o}, 32'd1);
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        @(negedge wb_clk_i);
        chk("b2b_ack_4", {31'd0, wbs_ack_o}, 32'd0);

        // Reset in the middle of a run
        wr(2'd0, 4'hF, 32'h00051401);
        repeat (10) @(negedge wb_clk_i);
        chk("mid_busy", {31'd0, busy_o}, 32'd1);
        chk("mid_stim", {28'd0, stim_o}, 32'd1);
        wb_rst_ni = 1'b0;
        #1;
        chk("rstmid_busy", {31'd0, busy_o}, 32'd0);
        chk("rstmid_stim", {28'd0, stim_o}, 32'd0);
        chk("rstmid_done", {31'd0, done_o}, 32'd0);
        chk("rstmid_dat", wbs_dat_o, 32'd0);
        repeat (2) @(negedge wb_clk_i);
        wb_rst_ni = 1'b1;
        rd(2'd2, 32'h001F0000, "rstmid_status");
        rd(2'd0, 32'h00000000, "rstmid_ctrl");

        repeat (2) @(negedge wb_clk_i);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
